sha256_stream_hasher: RTL

Memory-mapped SHA-256 engine that hashes a whole-word message of runtime-selected length from shared word-addressed memory and writes the 256-bit digest back to memory. It generalises the fixed-length hasher with several additions:
- a runtime word count;
- correct multi-block padding for every length;
- an optional caller-supplied initial hash (midstate) with a length-offset input, so bitcoin-style second-block hashing can be chained;
- a parallel digest output.

It sits between the testbench/host controller and the single-port memory used by the other hashing blocks.

---
 rtl/sha256_stream_hasher.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/sha256_stream_hasher.sv
// Memory-mapped SHA-256 engine: streams an N-word message from memory, pads it on the fly,
// optionally resumes from a caller midstate, and writes the 256-bit digest back to memory.
module sha256_stream_hasher #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned LEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] message_addr,
  input  logic [ADDR_W-1:0] output_addr,
  input  logic [LEN_W-1:0]  num_words,
  input  logic              use_iv,
  input  logic [255:0]      iv,
  input  logic [7:0]        pre_blocks,
  output logic              done,
  output logic [255:0]      hash_out,
  output logic              mem_clk,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_write_data,
  input  logic [31:0]       mem_read_data
);

  localparam int unsigned CNT_W = 7;
  localparam int unsigned BLK_W = LEN_W + 1;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [255:0] H_INIT =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  typedef enum logic [2:0] {IDLE, READ, COMPUTE, UPDATE, WRITE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [BLK_W-1:0]   blk_q, nblk_q;
  logic [LEN_W-1:0]   len_q;
  logic [63:0]        bitlen_q;
  logic [ADDR_W-1:0]  out_addr_q;
  logic [31:0]        h_q  [8];
  logic [31:0]        wv_q [8];
  logic [31:0]        w_q  [16];

  logic [BLK_W-1:0]   n_idx, last_idx;
  logic [3:0]         rd_k;
  logic [31:0]        pad_word, w_next, t1, t2;
  logic [31:0]        hsum [8];

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  assign mem_clk = clk;

  // Word k-1 of the padded stream is on the read bus during READ cycle k
  always_comb begin
    rd_k     = 4'(cnt_q - CNT_W'(1));
    n_idx    = {blk_q[BLK_W-5:0], rd_k};
    last_idx = {nblk_q[BLK_W-5:0], 4'd0} - BLK_W'(1);
    pad_word = '0;
    if (n_idx < BLK_W'(len_q))                pad_word = mem_read_data;
    else if (n_idx == BLK_W'(len_q))          pad_word = 32'h8000_0000;
    else if (n_idx == last_idx - BLK_W'(1))   pad_word = bitlen_q[63:32];
    else if (n_idx == last_idx)               pad_word = bitlen_q[31:0];
  end

  // One compression round and the next schedule word from the 16-word window
  always_comb begin
    t1 = wv_q[7] + (rotr(wv_q[4], 6) ^ rotr(wv_q[4], 11) ^ rotr(wv_q[4], 25))
       + ((wv_q[4] & wv_q[5]) ^ (~wv_q[4] & wv_q[6])) + K[cnt_q[5:0]] + w_q[0];
    t2 = (rotr(wv_q[0], 2) ^ rotr(wv_q[0], 13) ^ rotr(wv_q[0], 22))
       + ((wv_q[0] & wv_q[1]) ^ (wv_q[0] & wv_q[2]) ^ (wv_q[1] & wv_q[2]));
    w_next = (rotr(w_q[14], 17) ^ rotr(w_q[14], 19) ^ (w_q[14] >> 10)) + w_q[9]
           + (rotr(w_q[1], 7) ^ rotr(w_q[1], 18) ^ (w_q[1] >> 3)) + w_q[0];
    for (int i = 0; i < 8; i++) hsum[i] = h_q[i] + wv_q[i];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = READ;
      READ:    if (cnt_q == CNT_W'(16)) state_d = COMPUTE;
      COMPUTE: if (cnt_q == CNT_W'(63)) state_d = UPDATE;
      UPDATE:  state_d = (blk_q + BLK_W'(1) < nblk_q) ? READ : WRITE;
      WRITE:   if (cnt_q == CNT_W'(7)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q          <= '0;
      blk_q          <= '0;
      nblk_q         <= '0;
      len_q          <= '0;
      bitlen_q       <= '0;
      out_addr_q     <= '0;
      done           <= 1'b1;
      hash_out       <= '0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_write_data <= '0;
      for (int i = 0; i < 8; i++) begin
        h_q[i]  <= '0;
        wv_q[i] <= '0;
      end
      for (int i = 0; i < 16; i++) w_q[i] <= '0;
    end else begin
      cnt_q <= (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);
      done  <= (state_d == IDLE);
      case (state_q)
        IDLE: begin
          mem_we <= 1'b0;
          if (start) begin
            out_addr_q <= output_addr;
            mem_addr   <= message_addr;
            len_q      <= num_words;
            nblk_q     <= (BLK_W'(num_words) + BLK_W'(18)) >> 4;
            bitlen_q   <= (64'(num_words) << 5) + (64'(pre_blocks) << 9);
            blk_q      <= '0;
            for (int i = 0; i < 8; i++)
              h_q[i] <= use_iv ? iv[255-32*i -: 32] : H_INIT[255-32*i -: 32];
          end
        end
        READ: begin
          if (cnt_q != '0) begin
            for (int i = 0; i < 15; i++) w_q[i] <= w_q[i+1];
            w_q[15] <= pad_word;
          end
          if (cnt_q < CNT_W'(15)) mem_addr <= mem_addr + ADDR_W'(1);
          if (cnt_q == CNT_W'(16)) for (int i = 0; i < 8; i++) wv_q[i] <= h_q[i];
        end
        COMPUTE: begin
          for (int i = 0; i < 15; i++) w_q[i] <= w_q[i+1];
          w_q[15] <= w_next;
          for (int i = 1; i < 8; i++) wv_q[i] <= wv_q[i-1];
          wv_q[4] <= wv_q[3] + t1;
          wv_q[0] <= t1 + t2;
        end
        UPDATE: begin
          for (int i = 0; i < 8; i++) h_q[i] <= hsum[i];
          blk_q <= blk_q + BLK_W'(1);
          if (state_d == READ) begin
            mem_addr <= mem_addr + ADDR_W'(1);
          end else begin
            mem_we         <= 1'b1;
            mem_addr       <= out_addr_q;
            mem_write_data <= hsum[0];
          end
        end
        WRITE: begin
          if (cnt_q < CNT_W'(7)) begin
            mem_addr       <= mem_addr + ADDR_W'(1);
            mem_write_data <= h_q[3'(cnt_q + CNT_W'(1))];
          end else begin
            mem_we   <= 1'b0;
            hash_out <= {h_q[0], h_q[1], h_q[2], h_q[3], h_q[4], h_q[5], h_q[6], h_q[7]};
          end
        end
        default: ;
      endcase
    end
  end

endmodule
